// File: rtl/pcn6_pkg.sv
// Shared definitions for the degree-6 stochastic parity check node:
// run-sequencer state encoding and default geometry/timing values.
package pcn6_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DECODE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam int unsigned LP_D        = 6;
  localparam int unsigned LP_INIT_CYC = 4;
  localparam int unsigned LP_SAT_RUN  = 16;
  localparam int unsigned LP_SAT_W    = 8;
  localparam int unsigned LP_MAX_CYC  = 2048;
  localparam int unsigned LP_CYC_W    = 12;

endpackage

// File: rtl/pcn6_ctrl.sv
// Decode-run sequencer: IDLE/LOAD/DECODE/FIN FSM with the satisfied-run and
// decode-cycle counters; drives INIT/BUSY/DONE/CONV and the decode_en strobe.
module pcn6_ctrl
  import pcn6_pkg::*;
#(
  parameter int unsigned INIT_CYC = LP_INIT_CYC,
  parameter int unsigned SAT_RUN  = LP_SAT_RUN,
  parameter int unsigned SAT_W    = LP_SAT_W,
  parameter int unsigned MAX_CYC  = LP_MAX_CYC,
  parameter int unsigned CYC_W    = LP_CYC_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_parity,
  output logic o_init,
  output logic o_busy,
  output logic o_done,
  output logic o_conv,
  output logic o_decode_en
);

  localparam int unsigned LD_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [LD_W-1:0]  LP_LD_LAST  = LD_W'(INIT_CYC - 1);
  localparam logic [SAT_W-1:0] LP_RUN_LAST = SAT_W'(SAT_RUN - 1);
  localparam logic [CYC_W-1:0] LP_CYC_LAST = CYC_W'(MAX_CYC - 1);

  state_t            r_state;
  logic [LD_W-1:0]   r_ld;
  logic [SAT_W-1:0]  r_run;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_init;
  logic              r_busy;
  logic              r_done;
  logic              r_conv;
  logic              r_decode_en;

  logic [SAT_W-1:0]  w_run_nxt;
  logic              w_conv_hit;
  logic              w_timeout;

  // Next satisfied-run length and the two run-ending conditions for this sample.
  always_comb begin
    w_run_nxt  = r_run + SAT_W'(1);
    w_conv_hit = 1'b0;
    if (i_parity) begin
      w_run_nxt = {SAT_W{1'b0}};
    end else begin
      w_conv_hit = (r_run == LP_RUN_LAST);
    end
    w_timeout = (r_cyc == LP_CYC_LAST);
  end

  // Sequencer state, counters and registered run outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ld        <= {LD_W{1'b0}};
      r_run       <= {SAT_W{1'b0}};
      r_cyc       <= {CYC_W{1'b0}};
      r_init      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_conv      <= 1'b0;
      r_decode_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_ld    <= {LD_W{1'b0}};
            r_init  <= 1'b1;
            r_busy  <= 1'b1;
            r_conv  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (r_ld == LP_LD_LAST) begin
            r_state     <= ST_DECODE;
            r_init      <= 1'b0;
            r_decode_en <= 1'b1;
            r_run       <= {SAT_W{1'b0}};
            r_cyc       <= {CYC_W{1'b0}};
          end else begin
            r_ld <= r_ld + LD_W'(1);
          end
        end
        ST_DECODE: begin
          r_run <= w_run_nxt;
          r_cyc <= r_cyc + CYC_W'(1);
          // Convergence is tested first so it wins a tie with the cycle budget.
          if (w_conv_hit) begin
            r_state     <= ST_FIN;
            r_conv      <= 1'b1;
            r_done      <= 1'b1;
            r_decode_en <= 1'b0;
          end else if (w_timeout) begin
            r_state     <= ST_FIN;
            r_conv      <= 1'b0;
            r_done      <= 1'b1;
            r_decode_en <= 1'b0;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_init      <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_conv      <= 1'b0;
          r_decode_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_init      = r_init;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_conv      = r_conv;
  assign o_decode_en = r_decode_en;

endmodule

// File: rtl/pcn6.sv
// Degree-6 parity check node: extrinsic XOR array and registered R/SAT,
// with run sequencing delegated to pcn6_ctrl.
module pcn6
  import pcn6_pkg::*;
#(
  parameter int unsigned D        = LP_D,
  parameter int unsigned INIT_CYC = LP_INIT_CYC,
  parameter int unsigned SAT_RUN  = LP_SAT_RUN,
  parameter int unsigned SAT_W    = LP_SAT_W,
  parameter int unsigned MAX_CYC  = LP_MAX_CYC,
  parameter int unsigned CYC_W    = LP_CYC_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [D-1:0] i_q,
  output logic [D-1:0] o_r,
  output logic         o_init,
  output logic         o_busy,
  output logic         o_sat,
  output logic         o_done,
  output logic         o_conv
);

  // Each edge gets the parity of all other edges: full parity with its own bit removed.
  function automatic logic [D-1:0] extrinsic_f(input logic [D-1:0] q);
    logic [D-1:0] ext;
    logic         p;
    p = ^q;
    for (int i = 0; i < D; i++) begin
      ext[i] = p ^ q[i];
    end
    return ext;
  endfunction

  logic         w_parity;
  logic [D-1:0] w_ext;
  logic         w_decode_en;
  logic [D-1:0] r_r;
  logic         r_sat;

  assign w_parity = ^i_q;
  assign w_ext    = extrinsic_f(i_q);

  pcn6_ctrl #(
    .INIT_CYC (INIT_CYC),
    .SAT_RUN  (SAT_RUN),
    .SAT_W    (SAT_W),
    .MAX_CYC  (MAX_CYC),
    .CYC_W    (CYC_W)
  ) u_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_parity    (w_parity),
    .o_init      (o_init),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_conv      (o_conv),
    .o_decode_en (w_decode_en)
  );

  // Extrinsic and satisfied-parity registers, forced low outside DECODE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r   <= {D{1'b0}};
      r_sat <= 1'b0;
    end else if (w_decode_en) begin
      r_r   <= w_ext;
      r_sat <= ~w_parity;
    end else begin
      r_r   <= {D{1'b0}};
      r_sat <= 1'b0;
    end
  end

  assign o_r   = r_r;
  assign o_sat = r_sat;

endmodule

// File: tb/tb_pcn6.sv
// Self-checking bench for pcn6: three instances (default, MAX_CYC=32, MAX_CYC=16)
// checked cycle by cycle against a run-level reference model.
module tb_pcn6;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [5:0] q_v [3];
  logic [5:0] r_v [3];
  logic [2:0] init_v, busy_v, sat_v, done_v, conv_v;

  int checks   = 0;
  int failures = 0;

  logic [5:0] g_qs [$];

  always #5 clk = ~clk;

  pcn6 u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_q(q_v[0]), .o_r(r_v[0]),
    .o_init(init_v[0]), .o_busy(busy_v[0]), .o_sat(sat_v[0]), .o_done(done_v[0]), .o_conv(conv_v[0])
  );

  pcn6 #(.MAX_CYC(32)) u_to (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_q(q_v[1]), .o_r(r_v[1]),
    .o_init(init_v[1]), .o_busy(busy_v[1]), .o_sat(sat_v[1]), .o_done(done_v[1]), .o_conv(conv_v[1])
  );

  pcn6 #(.MAX_CYC(16)) u_tie (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_q(q_v[2]), .o_r(r_v[2]),
    .o_init(init_v[2]), .o_busy(busy_v[2]), .o_sat(sat_v[2]), .o_done(done_v[2]), .o_conv(conv_v[2])
  );

  function automatic bit par6(input logic [5:0] v);
    return bit'($countones(v) % 2);
  endfunction

  // Extrinsic reference: parity of the vector with bit i knocked out.
  function automatic logic [5:0] ext_ref(input logic [5:0] v);
    logic [5:0] e;
    logic [5:0] m;
    for (int i = 0; i < 6; i++) begin
      m    = v;
      m[i] = 1'b0;
      e[i] = par6(m);
    end
    return e;
  endfunction

  function automatic logic [5:0] rand_par(input bit odd);
    logic [5:0] v;
    v = 6'($urandom);
    if (par6(v) != odd) v[0] = ~v[0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: zeros, 1: random even, 2: alternating parity, 3: random with ~10% odd
  task automatic fill(input int mode, input int n);
    g_qs.delete();
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       g_qs.push_back(6'd0);
        1:       g_qs.push_back(rand_par(1'b0));
        2:       g_qs.push_back(rand_par((k % 2) == 0));
        default: g_qs.push_back(rand_par($urandom_range(9, 0) == 0));
      endcase
    end
  endtask

  // One full run on instance inst, Q taken from g_qs per DECODE cycle.
  task automatic do_run(input int inst, input int sat_run, input int max_cyc,
                        input int pulse_at, input int abort_at, input string tag);
    int         fin;
    bit         conv_exp;
    int         run;
    logic [5:0] q;
    fin = 0; conv_exp = 1'b0; run = 0;
    for (int k = 1; k <= max_cyc && fin == 0; k++) begin
      if (!par6(g_qs[k-1])) run++; else run = 0;
      if (run == sat_run) begin fin = k; conv_exp = 1'b1; end
      else if (k == max_cyc) begin fin = k; conv_exp = 1'b0; end
    end

    start_v[inst] = 1'b1;
    q_v[inst]     = 6'($urandom);
    step();
    start_v[inst] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({init_v[inst], busy_v[inst], done_v[inst], conv_v[inst], sat_v[inst]} !== 5'b11000 ||
          r_v[inst] !== 6'd0) begin
        failures++;
        $display("FAIL %s_load j=%0d init/busy/done/conv/sat=%b r=%b expected 11000 r=000000",
                 tag, j, {init_v[inst], busy_v[inst], done_v[inst], conv_v[inst], sat_v[inst]}, r_v[inst]);
      end
      q_v[inst] = 6'($urandom);
      step();
    end
    checks++;
    if ({init_v[inst], busy_v[inst], done_v[inst]} !== 3'b010 || r_v[inst] !== 6'd0) begin
      failures++;
      $display("FAIL %s_entry init/busy/done=%b r=%b expected 010 r=000000",
               tag, {init_v[inst], busy_v[inst], done_v[inst]}, r_v[inst]);
    end

    for (int k = 1; k <= fin; k++) begin
      q             = g_qs[k-1];
      q_v[inst]     = q;
      start_v[inst] = (k == pulse_at);
      step();
      start_v[inst] = 1'b0;
      checks++;
      if (r_v[inst] !== ext_ref(q) || sat_v[inst] !== !par6(q) ||
          done_v[inst] !== (k == fin) || busy_v[inst] !== 1'b1 || init_v[inst] !== 1'b0) begin
        failures++;
        $display("FAIL %s_decode k=%0d q=%b r=%b sat=%b done=%b busy=%b expected r=%b sat=%b done=%b busy=1",
                 tag, k, q, r_v[inst], sat_v[inst], done_v[inst], busy_v[inst],
                 ext_ref(q), !par6(q), (k == fin));
      end
      if (k == fin) begin
        checks++;
        if (conv_v[inst] !== conv_exp) begin
          failures++;
          $display("FAIL %s_conv got=%b expected=%b", tag, conv_v[inst], conv_exp);
        end
      end
      if (k == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({r_v[inst], init_v[inst], busy_v[inst], sat_v[inst], done_v[inst], conv_v[inst]} !== 11'd0) begin
          failures++;
          $display("FAIL %s_abort r=%b init/busy/sat/done/conv=%b expected all zero",
                   tag, r_v[inst], {init_v[inst], busy_v[inst], sat_v[inst], done_v[inst], conv_v[inst]});
        end
        return;
      end
    end

    q_v[inst] = 6'($urandom);
    step();
    checks++;
    if ({init_v[inst], busy_v[inst], done_v[inst], sat_v[inst]} !== 4'b0000 ||
        r_v[inst] !== 6'd0 || conv_v[inst] !== conv_exp) begin
      failures++;
      $display("FAIL %s_idle init/busy/done/sat=%b r=%b conv=%b expected 0000 r=000000 conv=%b",
               tag, {init_v[inst], busy_v[inst], done_v[inst], sat_v[inst]}, r_v[inst], conv_v[inst], conv_exp);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) q_v[i] = 6'($urandom);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({r_v[i], init_v[i], busy_v[i], sat_v[i], done_v[i], conv_v[i]} !== 11'd0) begin
        failures++;
        $display("FAIL reset inst=%0d r=%b init/busy/sat/done/conv=%b expected all zero",
                 i, r_v[i], {init_v[i], busy_v[i], sat_v[i], done_v[i], conv_v[i]});
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_decode();
    fill(1, 2048);
    do_run(0, 16, 2048, 0, 10, "rst_mid");
    step();
  endtask

  task automatic test_convergence();
    fill(0, 2048);
    do_run(0, 16, 2048, 0, 0, "conv");
  endtask

  task automatic test_extrinsic();
    fill(1, 2048);
    g_qs[0] = 6'b000101;
    g_qs[1] = 6'b000001;
    do_run(0, 16, 2048, 0, 0, "extr");
  endtask

  task automatic test_run_broken();
    fill(1, 2048);
    g_qs[15] = 6'b000001;
    do_run(0, 16, 2048, 0, 0, "broken");
  endtask

  task automatic test_timeout();
    fill(2, 32);
    do_run(1, 16, 32, 5, 0, "timeout");
  endtask

  task automatic test_tie();
    fill(0, 16);
    do_run(2, 16, 16, 0, 0, "tie");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      fill(3, 2048);
      do_run(0, 16, 2048, 0, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    fill(1, 2048);
    do_run(0, 16, 2048, 0, 0, "b2b_a");
    fill(3, 2048);
    do_run(0, 16, 2048, 0, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_reset_mid_decode();
    test_convergence();
    test_extrinsic();
    test_run_broken();
    test_timeout();
    test_tie();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
